// File: rtl/cmem_ctrl.sv
// Arbiter for the FIR coefficient SRAM: host load port vs. per-sample coefficient sweeps.
// Optional host readback path enabled by defining CMEM_READBACK_EN.
module cmem_ctrl #(
    parameter int AW    = 6,
    parameter int DW    = 16,
    parameter int NTAPS = 64,
    parameter int BASE  = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_host_valid,
    output logic          o_host_ready,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_data,
`ifdef CMEM_READBACK_EN
    input  logic          i_host_rd,
    output logic          o_host_rvalid,
    output logic [DW-1:0] o_host_rdata,
`endif
    input  logic          i_run_start,
    output logic          o_run_busy,
    output logic          o_run_overrun,
    output logic          o_run_done,
    output logic          o_coef_valid,
    output logic [AW-1:0] o_coef_idx,
    output logic [DW-1:0] o_coef,
    output logic          o_sram_cen,
    output logic          o_sram_wen,
    output logic [AW-1:0] o_sram_a,
    output logic [DW-1:0] o_sram_d,
    input  logic [DW-1:0] i_sram_q
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_RB    = 3'd4;

    localparam logic [AW:0]   LAST_K = (AW+1)'(NTAPS - 1);
    localparam logic [AW-1:0] BASE_A = AW'(BASE);

    logic [2:0]    r_state;
    logic [AW:0]   r_k;
    logic          r_pending;
    logic          r_cen;
    logic          r_wen;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_d;
    logic          r_coef_valid;
    logic [AW-1:0] r_coef_idx;
    logic          r_done;
    logic          r_overrun;

    logic          w_host_rd;
    logic          w_last;
    logic [AW:0]   w_k_inc;

`ifdef CMEM_READBACK_EN
    logic          r_rb_q;
    assign w_host_rd     = i_host_rd;
    assign o_host_rvalid = r_rb_q;
    assign o_host_rdata  = r_rb_q ? i_sram_q : '0;
`else
    assign w_host_rd     = 1'b0;
`endif

    assign w_last  = (r_k == LAST_K);
    assign w_k_inc = r_k + 1'b1;

    // A start queued during a host write is honoured as soon as IDLE is reached,
    // so the host port stays closed while it is pending.
    assign o_host_ready  = !i_rst && (r_state == S_IDLE) && !i_run_start && !r_pending;
    assign o_run_busy    = (r_state == S_RD) || (r_state == S_DRAIN);
    assign o_run_overrun = r_overrun;
    assign o_run_done    = r_done;
    assign o_coef_valid  = r_coef_valid;
    assign o_coef_idx    = r_coef_idx;
    assign o_coef        = i_sram_q;
    assign o_sram_cen    = r_cen;
    assign o_sram_wen    = r_wen;
    assign o_sram_a      = r_a;
    assign o_sram_d      = r_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_pending    <= 1'b0;
            r_cen        <= 1'b1;
            r_wen        <= 1'b1;
            r_a          <= '0;
            r_d          <= '0;
            r_coef_valid <= 1'b0;
            r_coef_idx   <= '0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef CMEM_READBACK_EN
            r_rb_q       <= 1'b0;
`endif
        end else begin
            r_coef_valid <= (r_state == S_RD);
            r_coef_idx   <= r_k[AW-1:0];
            r_done       <= (r_state == S_RD) && w_last;
            r_overrun    <= i_run_start && r_pending && (r_state != S_IDLE);
`ifdef CMEM_READBACK_EN
            r_rb_q       <= (r_state == S_RB);
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_run_start || r_pending) begin
                        r_state   <= S_RD;
                        r_k       <= '0;
                        r_pending <= 1'b0;
                        r_cen     <= 1'b0;
                        r_wen     <= 1'b1;
                        r_a       <= BASE_A;
                    end else if (i_host_valid) begin
                        r_state <= w_host_rd ? S_RB : S_WR;
                        r_cen   <= 1'b0;
                        r_wen   <= w_host_rd;
                        r_a     <= i_host_addr;
                        r_d     <= i_host_data;
                    end
                end
                S_WR, S_RB: begin
                    r_state <= S_IDLE;
                    r_cen   <= 1'b1;
                    r_wen   <= 1'b1;
                    if (i_run_start && !r_pending)
                        r_pending <= 1'b1;
                end
                S_RD: begin
                    if (i_run_start && !r_pending)
                        r_pending <= 1'b1;
                    if (w_last) begin
                        r_state <= S_DRAIN;
                        r_cen   <= 1'b1;
                    end else begin
                        r_k <= w_k_inc;
                        r_a <= BASE_A + w_k_inc[AW-1:0];
                    end
                end
                S_DRAIN: begin
                    r_k       <= '0;
                    r_pending <= 1'b0;
                    // A fresh start arriving in the drain cycle chains directly.
                    if (r_pending || i_run_start) begin
                        r_state <= S_RD;
                        r_cen   <= 1'b0;
                        r_wen   <= 1'b1;
                        r_a     <= BASE_A;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cen   <= 1'b1;
                    r_wen   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmem_ctrl.sv
// Directed self-checking bench for cmem_ctrl with a behavioural 64x16 SRAM model.
module tb_cmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [5:0]  host_addr = '0;
    logic [15:0] host_data = '0;
    logic        host_rd = 1'b0;
    logic        host_rvalid;
    logic [15:0] host_rdata;
    logic        run_start = 1'b0;
    logic        run_busy, run_overrun, run_done, coef_valid;
    logic [5:0]  coef_idx;
    logic [15:0] coef;
    logic        sram_cen, sram_wen;
    logic [5:0]  sram_a;
    logic [15:0] sram_d;
    logic [15:0] sram_q;

    logic [15:0] mem [64];
    logic [15:0] shadow [64];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cmem_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_host_valid(host_valid), .o_host_ready(host_ready),
        .i_host_addr(host_addr), .i_host_data(host_data),
`ifdef CMEM_READBACK_EN
        .i_host_rd(host_rd), .o_host_rvalid(host_rvalid), .o_host_rdata(host_rdata),
`endif
        .i_run_start(run_start), .o_run_busy(run_busy), .o_run_overrun(run_overrun),
        .o_run_done(run_done), .o_coef_valid(coef_valid), .o_coef_idx(coef_idx),
        .o_coef(coef), .o_sram_cen(sram_cen), .o_sram_wen(sram_wen),
        .o_sram_a(sram_a), .o_sram_d(sram_d), .i_sram_q(sram_q)
    );

`ifndef CMEM_READBACK_EN
    assign host_rvalid = 1'b0;
    assign host_rdata  = '0;
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        sram_q = '0;
    end

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q <= mem[sram_a];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [5:0] addr, input logic [15:0] data);
        int n;
        host_valid = 1'b1; host_rd = 1'b0; host_addr = addr; host_data = data;
        n = 0;
        while (!host_ready && n < 200) begin tick(); n++; end
        n_tests++;
        if (!host_ready) begin
            n_fail++;
            $display("FAIL host_wait: host_ready=%0b required 1 within 200 cycles", host_ready);
        end
        tick();
        host_valid = 1'b0;
        shadow[addr] = data;
    endtask

    // Entered in cycle t+1 after RUN_START was sampled; returns in cycle t+NTAPS+2.
    task automatic expect_sweep(input string name);
        n_tests++;
        if (run_busy !== 1'b1 || coef_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_issue: busy=%0b valid=%0b required busy=1 valid=0", name, run_busy, coef_valid);
        end
        for (int i = 0; i < 64; i++) begin
            tick();
            n_tests++;
            if (coef_valid !== 1'b1 || coef_idx !== 6'(i) || coef !== shadow[i] ||
                run_done !== (i == 63) || host_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_tap%0d: valid=%0b idx=%0d coef=%h done=%0b ready=%0b required valid=1 idx=%0d coef=%h done=%0b ready=0",
                         name, i, coef_valid, coef_idx, coef, run_done, host_ready, i, shadow[i], (i == 63));
            end
        end
        tick();
        n_tests++;
        if (coef_valid !== 1'b0 || run_busy !== 1'b0 || run_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end: valid=%0b busy=%0b done=%0b required 0 0 0", name, coef_valid, run_busy, run_done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        n_tests++;
        if (sram_cen !== 1'b1 || sram_wen !== 1'b1 || sram_a !== 6'd0 || sram_d !== 16'd0 ||
            coef_valid !== 1'b0 || coef_idx !== 6'd0 || run_busy !== 1'b0 || run_done !== 1'b0 ||
            run_overrun !== 1'b0 || host_ready !== 1'b0 || host_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: cen=%0b wen=%0b a=%0d d=%h valid=%0b idx=%0d busy=%0b done=%0b ovr=%0b ready=%0b required 1 1 0 0 0 0 0 0 0 0",
                     sram_cen, sram_wen, sram_a, sram_d, coef_valid, coef_idx, run_busy, run_done, run_overrun, host_ready);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: host_ready=%0b required 1", host_ready);
        end
    endtask

    task automatic test_write_and_sweep;
        host_write(6'd1, 16'd350);
        n_tests++;
        if (sram_cen !== 1'b0 || sram_wen !== 1'b0 || sram_a !== 6'd1 || sram_d !== 16'd350 || host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_pins: cen=%0b wen=%0b a=%0d d=%0d ready=%0b required 0 0 1 350 0", sram_cen, sram_wen, sram_a, sram_d, host_ready);
        end
        tick();
        run_start = 1'b1; tick(); run_start = 1'b0;
        expect_sweep("sweep1");
    endtask

    task automatic test_load_all;
        for (int i = 0; i < 64; i++) begin
            host_write(6'(i), 16'(1000 + i));
            tick();
        end
        run_start = 1'b1; tick(); run_start = 1'b0;
        expect_sweep("load_all");
    endtask

    task automatic test_start_vs_host;
        host_valid = 1'b1; host_addr = 6'd5; host_data = 16'h1234; run_start = 1'b1;
        #1;
        n_tests++;
        if (host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_ready: host_ready=%0b required 0", host_ready);
        end
        tick(); run_start = 1'b0;
        expect_sweep("prio_sweep");
        n_tests++;
        if (host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_idle_ready: host_ready=%0b required 1", host_ready);
        end
        tick(); host_valid = 1'b0;
        n_tests++;
        if (sram_cen !== 1'b0 || sram_wen !== 1'b0 || sram_a !== 6'd5 || sram_d !== 16'h1234) begin
            n_fail++;
            $display("FAIL prio_wr_pins: cen=%0b wen=%0b a=%0d d=%h required 0 0 5 1234", sram_cen, sram_wen, sram_a, sram_d);
        end
        shadow[5] = 16'h1234;
        tick();
        run_start = 1'b1; tick(); run_start = 1'b0;
        expect_sweep("prio_sweep2");
    endtask

    task automatic test_back_to_back;
        int n_done, n_ovr, exp_idx;
        logic exp_valid, exp_busy;
        n_done = 0; n_ovr = 0;
        run_start = 1'b1; tick(); run_start = 1'b0;
        for (int c = 2; c <= 131; c++) begin
            tick();
            exp_valid = (c <= 65) || (c >= 67 && c <= 130);
            exp_idx   = (c <= 65) ? c - 2 : c - 67;
            exp_busy  = (c != 131);
            if (run_done) n_done++;
            if (run_overrun) n_ovr++;
            n_tests++;
            if (coef_valid !== exp_valid || run_busy !== exp_busy ||
                (exp_valid && (coef_idx !== 6'(exp_idx) || coef !== shadow[exp_idx])) ||
                run_done !== (c == 65 || c == 130) || run_overrun !== (c == 23)) begin
                n_fail++;
                $display("FAIL b2b_cyc%0d: valid=%0b busy=%0b idx=%0d done=%0b ovr=%0b required valid=%0b busy=%0b idx=%0d done=%0b ovr=%0b",
                         c, coef_valid, run_busy, coef_idx, run_done, run_overrun,
                         exp_valid, exp_busy, exp_idx, (c == 65 || c == 130), (c == 23));
            end
            run_start = (c == 12 || c == 22);
        end
        run_start = 1'b0;
        n_tests++;
        if (n_done != 2 || n_ovr != 1) begin
            n_fail++;
            $display("FAIL b2b_counts: done_pulses=%0d overrun_pulses=%0d required 2 1", n_done, n_ovr);
        end
    endtask

    task automatic test_reset_mid;
        int n, n_bad;
        run_start = 1'b1; tick(); run_start = 1'b0;
        n = 0;
        while (!(coef_valid && coef_idx == 6'd30) && n < 100) begin tick(); n++; end
        n_tests++;
        if (!(coef_valid && coef_idx == 6'd30)) begin
            n_fail++;
            $display("FAIL rstmid_wait: tap 30 not seen, idx=%0d required 30", coef_idx);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ready: host_ready=%0b required 0", host_ready);
        end
        tick(); rst = 1'b0;
        n_tests++;
        if (coef_valid !== 1'b0 || sram_cen !== 1'b1 || sram_wen !== 1'b1 || run_busy !== 1'b0 ||
            run_done !== 1'b0 || run_overrun !== 1'b0 || sram_a !== 6'd0) begin
            n_fail++;
            $display("FAIL rstmid_state: valid=%0b cen=%0b wen=%0b busy=%0b done=%0b ovr=%0b a=%0d required 0 1 1 0 0 0 0",
                     coef_valid, sram_cen, sram_wen, run_busy, run_done, run_overrun, sram_a);
        end
        n_bad = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (run_done || coef_valid || run_busy) n_bad++;
        end
        n_tests++;
        if (n_bad != 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: active cycles=%0d required 0", n_bad);
        end
        run_start = 1'b1; tick(); run_start = 1'b0;
        expect_sweep("rstmid_sweep");
    endtask

`ifdef CMEM_READBACK_EN
    task automatic test_readback;
        int n;
        host_write(6'd63, 16'hBEEF);
        tick();
        host_valid = 1'b1; host_rd = 1'b1; host_addr = 6'd63;
        n = 0;
        while (!host_ready && n < 200) begin tick(); n++; end
        tick(); host_valid = 1'b0; host_rd = 1'b0;
        n_tests++;
        if (sram_cen !== 1'b0 || sram_wen !== 1'b1 || sram_a !== 6'd63 || host_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rb_pins: cen=%0b wen=%0b a=%0d rvalid=%0b required 0 1 63 0", sram_cen, sram_wen, sram_a, host_rvalid);
        end
        tick();
        n_tests++;
        if (host_rvalid !== 1'b1 || host_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rb_data: rvalid=%0b rdata=%h required 1 beef", host_rvalid, host_rdata);
        end
        tick();
        n_tests++;
        if (host_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rb_pulse: rvalid=%0b required 0", host_rvalid);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = '0;
        test_reset();
        test_write_and_sweep();
        test_load_all();
        test_start_vs_host();
        test_back_to_back();
        test_reset_mid();
`ifdef CMEM_READBACK_EN
        test_readback();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
